// File: rtl/cordic_pkg.sv
// Shared Q5.27 constants and sequencer state encoding for the CORDIC request controller.
package cordic_pkg;

    localparam int Q_W = 32;

    localparam logic signed [Q_W-1:0] PI      = 32'sd421657428;
    localparam logic signed [Q_W-1:0] TWO_PI  = 32'sd843314857;
    localparam logic signed [Q_W-1:0] HALF_PI = 32'sd210828714;
    localparam logic signed [Q_W-1:0] K_INV   = 32'sd81504109;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RANGE = 2'd1,
        FOLD  = 2'd2,
        ISSUE = 2'd3
    } state_e;

endpackage

// File: rtl/cordic_track_pipe.sv
// Shift register that follows each issued angle through the core latency,
// carrying the fold flag and requester tag alongside a valid bit.
module cordic_track_pipe
#(
    parameter int DEPTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             flip_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             tap_valid_o,
    output logic             tap_flip_o,
    output logic [TAG_W-1:0] tap_tag_o,
    output logic             any_valid_o
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0]            flip_q;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            flip_q <= '0;
            tag_q  <= '0;
        end else begin
            vld_q[0]  <= push_i;
            flip_q[0] <= flip_i;
            tag_q[0]  <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                flip_q[i] <= flip_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    assign tap_valid_o = vld_q[DEPTH-1];
    assign tap_flip_o  = flip_q[DEPTH-1];
    assign tap_tag_o   = tag_q[DEPTH-1];
    assign any_valid_o = |vld_q;

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Request sequencer for the pipelined CORDIC rotation core: range-reduces and folds
// each angle, issues it, and returns sign-corrected cos/sin with the request tag.
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 32,
    parameter int TAG_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_angle,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_cos,
    output logic signed [WIDTH-1:0] out_sin,
    output logic [TAG_W-1:0]        out_tag,
    output logic signed [WIDTH-1:0] cordic_x_start,
    output logic signed [WIDTH-1:0] cordic_y_start,
    output logic signed [WIDTH-1:0] cordic_angle,
    input  logic signed [WIDTH-1:0] cordic_cos,
    input  logic signed [WIDTH-1:0] cordic_sin,
    output logic                    busy
);

    localparam logic signed [WIDTH-1:0] PI_W      = WIDTH'(PI);
    localparam logic signed [WIDTH-1:0] TWO_PI_W  = WIDTH'(TWO_PI);
    localparam logic signed [WIDTH-1:0] HALF_PI_W = WIDTH'(HALF_PI);

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] ang_q, ang_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic                    flip_q, flip_d;
    logic signed [WIDTH-1:0] cang_q, cang_d;
    logic signed [WIDTH-1:0] wrap_up;
    logic                    push;

    logic                    iss_vld_q;
    logic                    iss_flip_q;
    logic [TAG_W-1:0]        iss_tag_q;

    logic                    tap_valid, tap_flip, trk_any;
    logic [TAG_W-1:0]        tap_tag;

    logic                    out_valid_q;
    logic signed [WIDTH-1:0] out_cos_q, out_sin_q;
    logic [TAG_W-1:0]        out_tag_q;

    // TWO_PI rounds one LSB above 2*PI, so -PI + TWO_PI lands just over PI and
    // would bounce forever; clamp that single case onto PI.
    assign wrap_up = ang_q + TWO_PI_W;

    always_comb begin
        state_d = state_q;
        ang_d   = ang_q;
        tag_d   = tag_q;
        flip_d  = flip_q;
        cang_d  = cang_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ang_d   = in_angle;
                    tag_d   = in_tag;
                    state_d = RANGE;
                end
            end
            RANGE: begin
                if (ang_q > PI_W) begin
                    ang_d = ang_q - TWO_PI_W;
                end else if (ang_q <= -PI_W) begin
                    ang_d = (wrap_up > PI_W) ? PI_W : wrap_up;
                end else begin
                    state_d = FOLD;
                end
            end
            FOLD: begin
                if (ang_q > HALF_PI_W) begin
                    ang_d  = ang_q - PI_W;
                    flip_d = 1'b1;
                end else if (ang_q < -HALF_PI_W) begin
                    ang_d  = ang_q + PI_W;
                    flip_d = 1'b1;
                end else begin
                    flip_d = 1'b0;
                end
                state_d = ISSUE;
            end
            ISSUE: begin
                cang_d  = ang_q;
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ang_q   <= '0;
            tag_q   <= '0;
            flip_q  <= 1'b0;
            cang_q  <= '0;
        end else begin
            state_q <= state_d;
            ang_q   <= ang_d;
            tag_q   <= tag_d;
            flip_q  <= flip_d;
            cang_q  <= cang_d;
        end
    end

    // Issue stage lines the tracking entry up with the registered core angle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_vld_q  <= 1'b0;
            iss_flip_q <= 1'b0;
            iss_tag_q  <= '0;
        end else begin
            iss_vld_q  <= push;
            iss_flip_q <= flip_q;
            iss_tag_q  <= tag_q;
        end
    end

    cordic_track_pipe #(
        .DEPTH (LATENCY),
        .TAG_W (TAG_W)
    ) u_track (
        .clk         (clk),
        .rst         (rst),
        .push_i      (iss_vld_q),
        .flip_i      (iss_flip_q),
        .tag_i       (iss_tag_q),
        .tap_valid_o (tap_valid),
        .tap_flip_o  (tap_flip),
        .tap_tag_o   (tap_tag),
        .any_valid_o (trk_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_cos_q   <= '0;
            out_sin_q   <= '0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= tap_valid;
            if (tap_valid) begin
                out_cos_q <= tap_flip ? -cordic_cos : cordic_cos;
                out_sin_q <= tap_flip ? -cordic_sin : cordic_sin;
                out_tag_q <= tap_tag;
            end
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = out_valid_q;
    assign out_cos        = out_cos_q;
    assign out_sin        = out_sin_q;
    assign out_tag        = out_tag_q;
    assign cordic_x_start = WIDTH'(K_INV);
    assign cordic_y_start = '0;
    assign cordic_angle   = cang_q;
    assign busy           = (state_q != IDLE) || iss_vld_q || trk_any;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Scoreboard bench for cordic_seq_ctrl with a behavioural LATENCY-cycle core model.
module tb_cordic_seq_ctrl;

    localparam int W   = 32;
    localparam int LAT = 32;
    localparam int TW  = 4;
    localparam int ONE = 134217728;
    localparam int TOL = 64;

    typedef struct {
        int          c;
        int          s;
        logic [TW-1:0] tag;
        int          lat;
        int          acc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [W-1:0]  in_angle = '0;
    logic [TW-1:0]        in_tag = '0;
    logic                 out_valid;
    logic signed [W-1:0]  out_cos, out_sin;
    logic [TW-1:0]        out_tag;
    logic signed [W-1:0]  cordic_x_start, cordic_y_start, cordic_angle;
    logic signed [W-1:0]  cordic_cos, cordic_sin;
    logic                 busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   npulse = 0;
    exp_t sb[$];

    cordic_seq_ctrl #(.WIDTH(W), .LATENCY(LAT), .TAG_W(TW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_angle       (in_angle),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_cos        (out_cos),
        .out_sin        (out_sin),
        .out_tag        (out_tag),
        .cordic_x_start (cordic_x_start),
        .cordic_y_start (cordic_y_start),
        .cordic_angle   (cordic_angle),
        .cordic_cos     (cordic_cos),
        .cordic_sin     (cordic_sin),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: the output reflects the angle presented LAT cycles earlier.
    logic signed [W-1:0] cdl [LAT];
    initial for (int i = 0; i < LAT; i++) cdl[i] = '0;
    always @(posedge clk) begin
        cdl[0] <= cordic_angle;
        for (int i = 1; i < LAT; i++) cdl[i] <= cdl[i-1];
    end

    function automatic logic signed [W-1:0] q_cos(input logic signed [W-1:0] a);
        real r;
        r = $itor(a) / 134217728.0;
        return W'($rtoi($cos(r) * 134217728.0));
    endfunction

    function automatic logic signed [W-1:0] q_sin(input logic signed [W-1:0] a);
        real r;
        r = $itor(a) / 134217728.0;
        return W'($rtoi($sin(r) * 134217728.0));
    endfunction

    always_comb begin
        cordic_cos = q_cos(cdl[LAT-1]);
        cordic_sin = q_sin(cdl[LAT-1]);
    end

    task automatic chk(input string nm, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic bit near(input int a, input int b);
        int d;
        d = a - b;
        return (d <= TOL) && (d >= -TOL);
    endfunction

    task automatic send(input int ang, input logic [TW-1:0] tag, input int ec, input int es,
                        input int nred, input bit hold, output int acc);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_angle = ang;
        in_tag   = tag;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 1'b0, n, 200);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc   = cyc;
        e.c   = ec;
        e.s   = es;
        e.tag = tag;
        e.lat = LAT + 5 + nred;
        e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size() == 0, sb.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                npulse++;
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1'b0, out_tag, -1);
                end else begin
                    e = sb.pop_front();
                    chk("out_tag", out_tag == e.tag, out_tag, e.tag);
                    chk("out_cos", near(out_cos, e.c), out_cos, e.c);
                    chk("out_sin", near(out_sin, e.s), out_sin, e.s);
                    chk("latency", (cyc - e.acc) == e.lat, cyc - e.acc, e.lat);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a0, a1, a2, a3, dummy, pbefore;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("rst_in_ready", in_ready == 1'b1, in_ready, 1);
        chk("rst_busy", busy == 1'b0, busy, 0);
        chk("rst_out_cos", out_cos == 0, out_cos, 0);
        chk("rst_cordic_angle", cordic_angle == 0, cordic_angle, 0);
        chk("x_start", cordic_x_start == 81504109, cordic_x_start, 81504109);
        chk("y_start", cordic_y_start == 0, cordic_y_start, 0);
        @(negedge clk);
        rst = 1'b0;

        send(0, 4'd1, ONE, 0, 0, 1'b0, dummy);
        drain();
        send(1264972285, 4'd2, -ONE, 0, 1, 1'b0, dummy);
        send(-843314857, 4'd3, ONE, 0, 1, 1'b0, dummy);
        send(1686629713, 4'd4, ONE, 0, 2, 1'b0, dummy);
        send(316243071, 4'd5, -94906266, 94906266, 0, 1'b0, dummy);
        send(-421657428, 4'd6, -ONE, 0, 1, 1'b0, dummy);
        send(421657428, 4'd7, -ONE, 0, 0, 1'b0, dummy);
        send(-210828714, 4'd8, 0, -ONE, 0, 1'b0, dummy);
        drain();

        send(0, 4'd0, ONE, 0, 0, 1'b1, a0);
        send(70276238, 4'd1, 116235962, 67108864, 0, 1'b1, a1);
        send(-140552476, 4'd2, 67108864, -116235962, 0, 1'b1, a2);
        send(210828714, 4'd3, 0, ONE, 0, 1'b1, a3);
        @(negedge clk);
        in_valid = 1'b0;
        chk("spacing_1", (a1 - a0) == 4, a1 - a0, 4);
        chk("spacing_2", (a2 - a1) == 4, a2 - a1, 4);
        chk("spacing_3", (a3 - a2) == 4, a3 - a2, 4);
        drain();
        repeat (2) @(negedge clk);
        chk("idle_busy", busy == 1'b0, busy, 0);

        send(0, 4'd9, ONE, 0, 0, 1'b0, dummy);
        send(70276238, 4'd10, 116235962, 67108864, 0, 1'b0, dummy);
        repeat (5) @(negedge clk);
        chk("busy_in_flight", busy == 1'b1, busy, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_out_valid", out_valid == 1'b0, out_valid, 0);
        chk("midrst_in_ready", in_ready == 1'b1, in_ready, 1);
        chk("midrst_busy", busy == 1'b0, busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pbefore = npulse;
        repeat (LAT + 20) @(negedge clk);
        chk("no_stale_result", npulse == pbefore, npulse - pbefore, 0);

        send(-140552476, 4'd11, 67108864, -116235962, 0, 1'b0, dummy);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
